// File: rtl/note_player.sv
// Programmable square-wave tone generator: semitone table plus octave shift,
// plays one note for dur_ms milliseconds followed by a fixed silent gap.
module note_player #(
  parameter int WIDTH    = 28,
  parameter int TICK_DIV = 50000,
  parameter int GAP_MS   = 10,
  parameter int DUR_W    = 12
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       note,
  input  logic [2:0]       octave,
  input  logic [DUR_W-1:0] dur_ms,
  output logic             clock_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
  localparam int MS_W   = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   GAP_LAST  = MS_W'(GAP_MS - 1);

  function automatic logic [WIDTH-1:0] base_period(input logic [3:0] n);
    case (n)
      4'd0:    base_period = WIDTH'(95532);
      4'd1:    base_period = WIDTH'(90171);
      4'd2:    base_period = WIDTH'(85110);
      4'd3:    base_period = WIDTH'(80334);
      4'd4:    base_period = WIDTH'(75826);
      4'd5:    base_period = WIDTH'(71571);
      4'd6:    base_period = WIDTH'(67554);
      4'd7:    base_period = WIDTH'(63763);
      4'd8:    base_period = WIDTH'(60184);
      4'd9:    base_period = WIDTH'(56806);
      4'd10:   base_period = WIDTH'(53619);
      4'd11:   base_period = WIDTH'(50609);
      default: base_period = '0;
    endcase
  endfunction

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_period;
  logic [WIDTH-1:0]  r_per_cnt;
  logic              r_rest;
  logic [DUR_W-1:0]  r_dur;
  logic [TICK_W-1:0] r_tick;
  logic [MS_W-1:0]   r_ms;

  logic [WIDTH-1:0]  w_start_period;
  logic [WIDTH-1:0]  w_per_next;
  logic [WIDTH-1:0]  w_half;
  logic [MS_W-1:0]   w_dur_last;
  logic              w_tick_wrap;

  assign w_start_period = base_period(note) >> octave;
  assign w_per_next     = (r_per_cnt == r_period - 1'b1) ? '0 : r_per_cnt + 1'b1;
  assign w_half         = r_period >> 1;
  assign w_dur_last     = MS_W'(r_dur) - MS_W'(1);
  assign w_tick_wrap    = (r_tick == TICK_LAST);

  // clock_out is registered from the *next* period count so the output edge
  // lines up with the counter value it represents.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_period  <= '0;
      r_per_cnt <= '0;
      r_rest    <= 1'b0;
      r_dur     <= '0;
      r_tick    <= '0;
      r_ms      <= '0;
      clock_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: done defaults low every cycle; only the terminating branches raise it.
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          clock_out <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            if (dur_ms == '0) begin
              done <= 1'b1;
            end else begin
              r_state   <= PLAY;
              busy      <= 1'b1;
              r_period  <= w_start_period;
              r_rest    <= (note >= 4'd12);
              r_dur     <= dur_ms;
              r_per_cnt <= '0;
              r_tick    <= '0;
              r_ms      <= '0;
              clock_out <= (note < 4'd12);
            end
          end
        end

        PLAY: begin
          r_per_cnt <= w_per_next;
          clock_out <= !r_rest && (w_per_next < w_half);
          if (w_tick_wrap) begin
            r_tick <= '0;
            if (r_ms == w_dur_last) begin
              r_ms      <= '0;
              clock_out <= 1'b0;
              if (GAP_MS == 0) begin
                r_state <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_state <= GAP;
              end
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        GAP: begin
          clock_out <= 1'b0;
          if (w_tick_wrap) begin
            r_tick <= '0;
            if (r_ms == GAP_LAST) begin
              r_ms    <= '0;
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          clock_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: vector table driven through a scoreboard; a negedge
// monitor measures each command and compares against the queued expectation.
module tb_note_player;

  localparam int TICK_DIV = 1000;
  localparam int GAP_MS   = 2;
  localparam int DUR_W    = 12;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       note;
  logic [2:0]       octave;
  logic [DUR_W-1:0] dur_ms;
  logic             clock_out;
  logic             busy;
  logic             done;

  note_player #(
    .WIDTH(28), .TICK_DIV(TICK_DIV), .GAP_MS(GAP_MS), .DUR_W(DUR_W)
  ) dut (
    .clock_in (clk),
    .reset    (rst),
    .start    (start),
    .note     (note),
    .octave   (octave),
    .dur_ms   (dur_ms),
    .clock_out(clock_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int busy_cyc;
    int hi;
    int lo;
    int first;
  } exp_t;

  typedef struct {
    logic [3:0]       note;
    logic [2:0]       oct;
    logic [DUR_W-1:0] dur;
    exp_t             exp;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: measures busy length, first high/low run and idle glitches.
  initial begin
    int m_busy, m_hi, m_lo, m_phase, m_first, m_stray;
    exp_t e;
    m_busy = 0; m_hi = 0; m_lo = 0; m_phase = 0; m_first = 0; m_stray = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_hi = 0; m_lo = 0; m_phase = 0; m_first = 0; m_stray = 0;
      end else begin
        if (busy) begin
          if (m_busy == 0) m_first = int'(clock_out);
          m_busy++;
          case (m_phase)
            0: if (clock_out) m_hi++;
               else if (m_hi > 0) begin m_phase = 1; m_lo = 1; end
            1: if (!clock_out) m_lo++;
               else m_phase = 2;
            default: ;
          endcase
        end else if (clock_out) begin
          m_stray++;
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("busy_cycles", m_busy, e.busy_cyc);
            check("high_run", m_hi, e.hi);
            check("low_run", m_lo, e.lo);
            check("first_level", m_first, e.first);
            check("idle_tone", m_stray, 0);
            check("busy_at_done", int'(busy), 0);
          end
          m_busy = 0; m_hi = 0; m_lo = 0; m_phase = 0; m_first = 0; m_stray = 0;
        end
      end
    end
  end

  task automatic wait_done(input int budget, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", n, -1);
  endtask

  task automatic drive_start(input vec_t v, input bit push);
    @(posedge clk); #1;
    note = v.note; octave = v.oct; dur_ms = v.dur; start = 1'b1;
    if (push) sb_q.push_back(v.exp);
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs to prove they were latched.
    note = 4'($urandom); octave = 3'($urandom); dur_ms = DUR_W'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    drive_start(v, 1'b1);
    wait_done(v.exp.busy_cyc + 20, lat);
    check("done_latency", lat, v.exp.busy_cyc + 1);
  endtask

  initial begin
    int lat, n_done;
    vec_t v;

    //           note    oct   dur      busy   hi    lo   first
    vecs[0] = '{4'd11, 3'd7, 12'd2,  '{4000,  197,  198, 1}};
    vecs[1] = '{4'd1,  3'd3, 12'd12, '{14000, 5635, 5636, 1}};
    vecs[2] = '{4'd13, 3'd0, 12'd3,  '{5000,  0,    0,    0}};
    vecs[3] = '{4'd0,  3'd5, 12'd4,  '{6000,  1492, 1493, 1}};
    vecs[4] = '{4'd9,  3'd6, 12'd1,  '{3000,  443,  444,  1}};
    vecs[5] = '{4'd4,  3'd2, 12'd0,  '{0,     0,    0,    0}};
    vecs[6] = '{4'd15, 3'd7, 12'd1,  '{3000,  0,    0,    0}};

    rst = 1'b1; start = 1'b0; note = '0; octave = '0; dur_ms = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom); note = 4'($urandom);
      octave = 3'($urandom); dur_ms = DUR_W'($urandom);
      @(negedge clk);
      check("reset_outputs", int'({clock_out, busy, done}), 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({clock_out, busy, done}), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Start pulse during PLAY must be ignored.
    drive_start(vecs[0], 1'b1);
    repeat (300) @(posedge clk);
    #1;
    note = 4'd0; octave = 3'd0; dur_ms = 12'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5000, lat);
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("ignored_start_activity", n_done, 0);

    // Back-to-back: new start accepted in the done cycle.
    drive_start(vecs[4], 1'b1);
    wait_done(4000, lat);
    note = 4'd11; octave = 3'd7; dur_ms = 12'd1; start = 1'b1;
    v = vecs[0];
    v.dur = 12'd1;
    v.exp.busy_cyc = 3000;
    sb_q.push_back(v.exp);
    @(posedge clk); #1;
    start = 1'b0; note = 4'd0; octave = 3'd0;
    @(negedge clk);
    check("b2b_busy", int'(busy), 1);
    check("b2b_tone", int'(clock_out), 1);
    wait_done(4000, lat);

    // Reset 500 cycles into a note: immediate clear, no done.
    v = vecs[0];
    v.dur = 12'd3;
    drive_start(v, 1'b0);
    repeat (499) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs", int'({clock_out, busy, done}), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_vec(vecs[0]);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
